// File: rtl/mem_slot_arbiter.sv
// mem_slot_arbiter: assigns each cend-framed DRAM slot to video, CPU or DMA (or leaves it idle).
// Optional refresh support is built in when MEM_REFRESH_EN is defined.
module mem_slot_arbiter #(
    parameter int unsigned DMA_STARVE  = 8,
    parameter int unsigned REFRESH_MAX = 64
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cend,
    input  logic        i_pre_cend,
    input  logic        i_video_go,
    input  logic [1:0]  i_video_bw,
    input  logic [20:0] i_video_addr,
    output logic        o_video_next,
    output logic        o_video_strobe,
    input  logic        i_cpu_req,
    input  logic        i_cpu_rnw,
    input  logic [20:0] i_cpu_addr,
    output logic        o_cpu_next,
    output logic        o_cpu_strobe,
    input  logic        i_dma_req,
    input  logic        i_dma_rnw,
    input  logic [20:0] i_dma_addr,
    output logic        o_dma_next,
    output logic        o_dma_strobe,
    output logic        o_dram_req,
    output logic        o_dram_rnw,
    output logic [20:0] o_dram_addr,
    output logic [1:0]  o_dram_owner
);

    typedef enum logic [1:0] {
        OwnIdle  = 2'b00,
        OwnVideo = 2'b01,
        OwnCpu   = 2'b10,
        OwnDma   = 2'b11
    } owner_e;

    localparam logic [3:0] StarveMax = 4'(DMA_STARVE);

    logic [2:0]  r_slot_cnt;
    logic [3:0]  r_starve_cnt;
    owner_e      r_owner;
    logic        r_req;
    logic        r_rnw;
    logic [20:0] r_addr;
    logic        r_video_next;
    logic        r_cpu_next;
    logic        r_dma_next;

    logic [2:0]  w_slot_nxt;
    logic        w_video_slot;
    logic        w_dma_starved;
    owner_e      w_owner;
    logic        w_req;
    logic        w_rnw;
    logic [20:0] w_addr;
    logic [3:0]  w_starve_nxt;

`ifdef MEM_REFRESH_EN
    localparam int unsigned RefW = $clog2(REFRESH_MAX + 1);
    localparam logic [RefW-1:0] RefMax = RefW'(REFRESH_MAX);

    logic [RefW-1:0] r_ref_cnt;
    logic [7:0]      r_ref_row;
    logic            r_ref_due;
    logic            w_refresh;
`endif

    // Video eligibility is judged on the slot number that starts at this cend.
    always_comb begin
        w_slot_nxt = r_slot_cnt + 3'd1;
        case (i_video_bw)
            2'b00:   w_video_slot = (w_slot_nxt == 3'd0);
            2'b01:   w_video_slot = (w_slot_nxt[1:0] == 2'd0);
            2'b10:   w_video_slot = ~w_slot_nxt[0];
            default: w_video_slot = 1'b1;
        endcase
    end

    assign w_dma_starved = (r_starve_cnt == StarveMax);

    always_comb begin
        w_owner = OwnIdle;
        w_req   = 1'b0;
        w_rnw   = 1'b0;
        w_addr  = '0;
`ifdef MEM_REFRESH_EN
        w_refresh = 1'b0;
`endif
        if (i_video_go && w_video_slot) begin
            w_owner = OwnVideo;
            w_req   = 1'b1;
            w_rnw   = 1'b1;
            w_addr  = i_video_addr;
        end
`ifdef MEM_REFRESH_EN
        else if (r_ref_due) begin
            w_refresh = 1'b1;
        end
`endif
        else if (i_dma_req && w_dma_starved) begin
            w_owner = OwnDma;
            w_req   = 1'b1;
            w_rnw   = i_dma_rnw;
            w_addr  = i_dma_addr;
        end else if (i_cpu_req) begin
            w_owner = OwnCpu;
            w_req   = 1'b1;
            w_rnw   = i_cpu_rnw;
            w_addr  = i_cpu_addr;
        end else if (i_dma_req) begin
            w_owner = OwnDma;
            w_req   = 1'b1;
            w_rnw   = i_dma_rnw;
            w_addr  = i_dma_addr;
        end else begin
`ifdef MEM_REFRESH_EN
            w_refresh = 1'b1;
`endif
        end
`ifdef MEM_REFRESH_EN
        // Refresh keeps owner idle so no requester sees a strobe for it.
        if (w_refresh) begin
            w_req  = 1'b1;
            w_rnw  = 1'b1;
            w_addr = {13'd0, r_ref_row};
        end
`endif
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!i_dma_req || (w_owner == OwnDma)) begin
            w_starve_nxt = '0;
        end else if (r_starve_cnt != StarveMax) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_slot_cnt   <= '0;
            r_starve_cnt <= '0;
            r_owner      <= OwnIdle;
            r_req        <= 1'b0;
            r_rnw        <= 1'b0;
            r_addr       <= '0;
            r_video_next <= 1'b0;
            r_cpu_next   <= 1'b0;
            r_dma_next   <= 1'b0;
        end else begin
            r_video_next <= i_cend && (w_owner == OwnVideo);
            r_cpu_next   <= i_cend && (w_owner == OwnCpu);
            r_dma_next   <= i_cend && (w_owner == OwnDma);
            if (i_cend) begin
                r_slot_cnt   <= w_slot_nxt;
                r_starve_cnt <= w_starve_nxt;
                r_owner      <= w_owner;
                r_req        <= w_req;
                r_rnw        <= w_rnw;
                r_addr       <= w_addr;
            end
        end
    end

`ifdef MEM_REFRESH_EN
    // Overdue state is sampled at pre_cend so the cend decision sees a settled flag.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ref_cnt <= '0;
            r_ref_row <= '0;
            r_ref_due <= 1'b0;
        end else if (i_cend) begin
            if (w_refresh) begin
                r_ref_cnt <= '0;
                r_ref_row <= r_ref_row + 8'd1;
                r_ref_due <= 1'b0;
            end else if (r_ref_cnt != RefMax) begin
                r_ref_cnt <= r_ref_cnt + 1'b1;
            end
        end else if (i_pre_cend) begin
            r_ref_due <= (r_ref_cnt >= RefMax);
        end
    end
`else
    logic [7:0] w_unused_refresh_cfg;
    assign w_unused_refresh_cfg = {i_pre_cend, 7'(REFRESH_MAX)};
`endif

    // A read slot delivers its data as the slot closes.
    assign o_video_strobe = i_cend && r_req && r_rnw && (r_owner == OwnVideo);
    assign o_cpu_strobe   = i_cend && r_req && r_rnw && (r_owner == OwnCpu);
    assign o_dma_strobe   = i_cend && r_req && r_rnw && (r_owner == OwnDma);

    assign o_video_next = r_video_next;
    assign o_cpu_next   = r_cpu_next;
    assign o_dma_next   = r_dma_next;
    assign o_dram_req   = r_req;
    assign o_dram_rnw   = r_rnw;
    assign o_dram_addr  = r_addr;
    assign o_dram_owner = r_owner;

    a_one_next : assert property (@(posedge i_clk) disable iff (i_rst)
        $onehot0({r_video_next, r_cpu_next, r_dma_next}));

endmodule
